// File: rtl/vigna_sram_responder_pkg.sv
// Shared definitions for the vigna SRAM responder: FSM state encoding,
// port-select encoding, the out-of-range error pattern and bus widths.
package vigna_sram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic        PORT_I      = 1'b0;
    localparam logic        PORT_D      = 1'b1;
    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;
    localparam int          DATA_W      = 32;
    localparam int          STRB_W      = DATA_W / 8;

    // The instruction port never writes, whatever its bus lines carry.
    function automatic logic [STRB_W-1:0] port_strb(input logic sel, input logic [STRB_W-1:0] strb);
        return (sel == PORT_D) ? strb : '0;
    endfunction

endpackage

// File: rtl/vigna_sram_array.sv
// Single-port synchronous word RAM with byte-lane write enables, registered
// read and read-before-write; one narrow memory per lane so each maps to a BRAM.
module vigna_sram_array
    import vigna_sram_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [AW-1:0]     i_addr,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rdata;

            always_ff @(posedge clk) begin
                if (i_en) begin
                    r_rdata <= r_mem[i_addr];
                    if (i_wstrb[gi]) begin
                        r_mem[i_addr] <= i_wdata[8*gi +: 8];
                    end
                end
            end

            assign o_rdata[8*gi +: 8] = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/vigna_sram_responder.sv
// Shared SRAM responder for the vigna instruction (i_*) and data (d_*) buses.
// Optional feature macro VIGNA_SRAM_BUS_ERR_EN adds i_err/d_err error strobes.
module vigna_sram_responder
    import vigna_sram_responder_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
`ifdef VIGNA_SRAM_BUS_ERR_EN
    output logic        i_err,
    output logic        d_err,
`endif
    output logic [31:0] d_rdata
);

    localparam int          AW     = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN   = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);
`ifdef VIGNA_SRAM_BUS_ERR_EN
    localparam logic [31:0] OOR_RDATA = ERR_PATTERN;
`else
    localparam logic [31:0] OOR_RDATA = 32'h0;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [3:0]  r_wait_cnt;
    logic        r_i_ready;
    logic        r_d_ready;
    logic        r_resp_oor;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic          w_i_req;
    logic          w_d_req;
    logic          w_accept;
    logic          w_accept_sel;
    logic          w_mem_en;
    logic [31:0]   w_offset;
    logic          w_in_range;
    logic [AW-1:0] w_index;
    logic [31:0]   w_arr_rdata;
    logic [31:0]   w_resp_data;

    // A port whose ready is high is still holding the request just served;
    // it must not be taken as a new request on that edge.
    assign w_i_req = i_valid && !r_i_ready;
    assign w_d_req = d_valid && !r_d_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_N) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept     = 1'b0;
        w_accept_sel = PORT_I;
        w_mem_en     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_accept     = w_i_req || w_d_req;
                w_accept_sel = w_d_req ? PORT_D : PORT_I;
            end
            ST_RESP: w_mem_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel      <= PORT_I;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_sel   <= w_accept_sel;
                r_addr  <= (w_accept_sel == PORT_D) ? d_addr : i_addr;
                r_wdata <= d_wdata;
                r_wstrb <= port_strb(w_accept_sel, d_wstrb);
            end
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= (r_wait_cnt == WAIT_N) ? 4'd0 : r_wait_cnt + 4'd1;
            end else if (w_accept && (WAIT_CYCLES > 0)) begin
                r_wait_cnt <= 4'd1;
            end
        end
    end

    // Subtraction wraps for addresses below the base, which the >= test rejects.
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_in_range = (r_addr >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
    assign w_index    = w_offset[AW+1:2];

    vigna_sram_array #(
        .DEPTH (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_addr  (w_index),
        .i_wstrb (w_in_range ? r_wstrb : 4'b0000),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_i_ready  <= 1'b0;
            r_d_ready  <= 1'b0;
            r_resp_oor <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_i_ready <= w_mem_en && (r_sel == PORT_I);
            r_d_ready <= w_mem_en && (r_sel == PORT_D);
            if (w_mem_en) begin
                r_resp_oor <= !w_in_range;
            end
            if (r_i_ready) begin
                r_i_rdata <= w_resp_data;
            end
            if (r_d_ready) begin
                r_d_rdata <= w_resp_data;
            end
        end
    end

    // The array output is live only in the ready cycle; afterwards each port
    // shows its own captured copy so the other port's traffic cannot disturb it.
    assign w_resp_data = r_resp_oor ? OOR_RDATA : w_arr_rdata;
    assign i_ready     = r_i_ready;
    assign d_ready     = r_d_ready;
    assign i_rdata     = r_i_ready ? w_resp_data : r_i_rdata;
    assign d_rdata     = r_d_ready ? w_resp_data : r_d_rdata;

`ifdef VIGNA_SRAM_BUS_ERR_EN
    logic r_i_err;
    logic r_d_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
        end else begin
            r_i_err <= w_mem_en && (r_sel == PORT_I) && !w_in_range;
            r_d_err <= w_mem_en && (r_sel == PORT_D) && !w_in_range;
        end
    end

    assign i_err = r_i_err;
    assign d_err = r_d_err;
`endif

endmodule

// File: tb/tb_vigna_sram_responder.sv
// Scoreboard bench for vigna_sram_responder: stimulus pushes expected
// responses from a word-array model, a monitor pops them on each ready pulse.
module tb_vigna_sram_responder;

    localparam int          W     = 2;
    localparam int          WORDS = 256;
    localparam logic [31:0] BASE  = 32'h0000_0400;
`ifdef VIGNA_SRAM_BUS_ERR_EN
    localparam logic [31:0] OOR_VAL = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] OOR_VAL = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_valid = 1'b0;
    logic        d_valid = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        i_ready;
    logic        d_ready;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
`ifdef VIGNA_SRAM_BUS_ERR_EN
    logic        i_err;
    logic        d_err;
`endif

    always #5 clk = ~clk;

    vigna_sram_responder #(
        .MEM_WORDS   (WORDS),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_addr  (d_addr),
        .d_rdata (d_rdata),
        .d_wdata (d_wdata),
`ifdef VIGNA_SRAM_BUS_ERR_EN
        .i_err   (i_err),
        .d_err   (d_err),
`endif
        .d_wstrb (d_wstrb)
    );

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          chk;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        exp_i[$];
    exp_t        exp_d[$];
    logic [31:0] mem [WORDS];
    bit          known [WORDS];
    exp_t        mon_e;
    logic        prev_i = 1'b0;
    logic        prev_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 4 * WORDS);
    endfunction

    // Reference: a plain word array; reads return the word before any write.
    function automatic exp_t model_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        exp_t e;
        e.err = !in_rng(a);
        if (e.err) begin
            e.data = OOR_VAL;
            e.chk  = 1'b1;
        end else begin
            int ix = int'((longint'(a) - longint'(BASE)) / 4);
            e.data = mem[ix];
            e.chk  = known[ix];
            for (int k = 0; k < 4; k++) begin
                if (st[k]) mem[ix][8*k +: 8] = wd[8*k +: 8];
            end
            if (st == 4'hF) known[ix] = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (i_ready || d_ready) check("ready_overlap", 32'(i_ready & d_ready), 32'd0);
        if (i_ready) begin
            check("i_pulse_width", 32'(prev_i), 32'd0);
            if (exp_i.size() == 0) begin
                check("i_unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_i.pop_front();
                if (mon_e.chk) check("i_rdata", i_rdata, mon_e.data);
`ifdef VIGNA_SRAM_BUS_ERR_EN
                check("i_err", 32'(i_err), 32'(mon_e.err));
`endif
                $display("xfer i rdata=%h", i_rdata);
            end
        end
        if (d_ready) begin
            check("d_pulse_width", 32'(prev_d), 32'd0);
            if (exp_d.size() == 0) begin
                check("d_unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_d.pop_front();
                if (mon_e.chk) check("d_rdata", d_rdata, mon_e.data);
`ifdef VIGNA_SRAM_BUS_ERR_EN
                check("d_err", 32'(d_err), 32'(mon_e.err));
`endif
                $display("xfer d rdata=%h", d_rdata);
            end
        end
        prev_i <= i_ready;
        prev_d <= d_ready;
    end

    // Entered and left at #1 after a rising edge with the bus idle. Valid is
    // held through the edge on which ready is seen, as the core does.
    task automatic xfer(input bit use_i, input logic [31:0] ia, input bit use_d,
                        input logic [31:0] da, input logic [31:0] wd, input logic [3:0] st,
                        input bit drop_early);
        bit got_i;
        bit got_d;
        int k;
        int exp_kd;
        int exp_ki;
        if (use_d) exp_d.push_back(model_access(da, wd, st));
        if (use_i) exp_i.push_back(model_access(ia, 32'h0, 4'h0));
        exp_kd  = 2 + W;
        exp_ki  = use_d ? 4 + 2 * W : 2 + W;
        i_addr  = ia;
        d_addr  = da;
        d_wdata = wd;
        d_wstrb = st;
        i_valid = use_i;
        d_valid = use_d;
        got_i   = !use_i;
        got_d   = !use_d;
        k       = 0;
        while (!(got_i && got_d) && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (got_d) d_valid = 1'b0;
            if (got_i) i_valid = 1'b0;
            if (drop_early && k == 1) d_valid = 1'b0;
            if (!got_d && d_ready) begin
                got_d = 1'b1;
                check("d_latency", 32'(k), 32'(exp_kd));
            end
            if (!got_i && i_ready) begin
                got_i = 1'b1;
                check("i_latency", 32'(k), 32'(exp_ki));
            end
        end
        if (!(got_i && got_d)) check("ready_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        d_valid = 1'b0;
        d_wstrb = 4'h0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] oor [4];
        oor[0] = 32'h0000_0000;
        oor[1] = BASE - 32'd4;
        oor[2] = BASE + 32'(4 * WORDS);
        oor[3] = 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) return oor[$urandom_range(0, 3)];
        return BASE + 32'($urandom_range(0, 4 * WORDS - 1));
    endfunction

    initial begin
        int mode;
        logic [3:0] st;

        repeat (3) @(posedge clk);
        #1;
        check("reset_i_ready", 32'(i_ready), 32'd0);
        check("reset_d_ready", 32'(d_ready), 32'd0);
        check("reset_i_rdata", i_rdata, 32'd0);
        check("reset_d_rdata", d_rdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int ix = 0; ix < WORDS; ix++) begin
            xfer(1'b0, 32'h0, 1'b1, BASE + 32'(4 * ix), $urandom, 4'hF, 1'b0);
        end

        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF, 1'b0);
        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
        check("full_write_readback", d_rdata, 32'h1122_3344);
        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h12, 32'hAABB_CCDD, 4'b0010, 1'b0);
        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
        check("strobe_merge", d_rdata, 32'h1122_CC44);

        xfer(1'b1, BASE, 1'b1, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
        xfer(1'b1, BASE + 32'h20, 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0);
        check("i_sees_d_write_first", i_rdata, 32'hCAFE_F00D);

        xfer(1'b0, 32'h0, 1'b1, BASE + 32'(4 * WORDS), 32'h0, 4'h0, 1'b0);
        check("oor_read_data", d_rdata, OOR_VAL);
        xfer(1'b1, BASE - 32'd4, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        xfer(1'b0, 32'h0, 1'b1, BASE + 32'(4 * WORDS), 32'h1357_9BDF, 4'hF, 1'b0);
        xfer(1'b0, 32'h0, 1'b1, BASE - 32'd4, 32'h2468_ACE0, 4'hF, 1'b0);
        xfer(1'b1, BASE, 1'b1, BASE + 32'(4 * WORDS - 4), 32'h0, 4'h0, 1'b0);
        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h30, 32'h7777_8888, 4'hF, 1'b1);
        xfer(1'b1, BASE + 32'h30, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h40, 32'h5A5A_1234, 4'hF, 1'b0);
        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h40, 32'h0, 4'h0, 1'b0);
        check("rdata_hold", d_rdata, 32'h5A5A_1234);
        d_addr  = BASE + 32'h40;
        d_wdata = 32'h0BAD_F00D;
        d_wstrb = 4'hF;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrun_d_ready", 32'(d_ready), 32'd0);
        check("midrun_d_rdata", d_rdata, 32'd0);
        check("midrun_i_rdata", i_rdata, 32'd0);
        d_valid = 1'b0;
        d_wstrb = 4'h0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        xfer(1'b0, 32'h0, 1'b1, BASE + 32'h40, 32'h0, 4'h0, 1'b0);
        check("aborted_write_dropped", d_rdata, 32'h5A5A_1234);

        repeat (300) begin
            mode = $urandom_range(0, 3);
            st   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            xfer(mode == 0 || mode == 2, rand_addr(), mode != 0, rand_addr(), $urandom, st,
                 $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("i_queue_drained", 32'(exp_i.size()), 32'd0);
        check("d_queue_drained", 32'(exp_d.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
